// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: assembles BEATS bus beats into one INST_LEN-bit instruction,
// buffers instructions in a DEPTH-entry FWFT FIFO and bounds the fetch with a program counter.
module inst_fetch_queue #(
  parameter int unsigned INST_LEN  = 220,
  parameter int unsigned BUS_W     = 64,
  parameter int unsigned BEATS     = 4,
  parameter int unsigned DEPTH_LOG = 4,
  parameter int unsigned CNT_LEN   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prog_start,
  input  logic [CNT_LEN-1:0]   prog_inst_num,
  input  logic [BUS_W-1:0]     s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [INST_LEN-1:0]  instruct,
  output logic                 inst_empty,
  input  logic                 inst_req,
  output logic                 busy,
  output logic                 done,
  output logic [DEPTH_LOG:0]   fill_level,
  output logic                 err_underflow
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG;
  localparam int unsigned LAST_W = INST_LEN - BUS_W * (BEATS - 1);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [DEPTH_LOG:0] FULL      = (DEPTH_LOG + 1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                       state_q;
  logic [CNT_LEN-1:0]           num_q, pushed_q, popped_q;
  logic [BEAT_W-1:0]            beat_q;
  logic [BUS_W*(BEATS-1)-1:0]   shadow_q;
  logic [INST_LEN-1:0]          mem_q [DEPTH];
  logic [DEPTH_LOG-1:0]         wr_q, rd_q;
  logic [DEPTH_LOG:0]           fill_q, fill_d;
  logic                         done_q, err_q;
  logic                         accept, push, pop;

  always_comb begin
    s_ready = (state_q == RUN) && (pushed_q < num_q) &&
              ((beat_q != LAST_BEAT) || (fill_q < FULL));
    accept  = s_valid && s_ready;
    push    = accept && (beat_q == LAST_BEAT);
    pop     = inst_req && (fill_q != '0);
    fill_d  = fill_q;
    if (push && !pop)
      fill_d = fill_q + (DEPTH_LOG + 1)'(1);
    else if (pop && !push)
      fill_d = fill_q - (DEPTH_LOG + 1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      num_q    <= '0;
      pushed_q <= '0;
      popped_q <= '0;
      beat_q   <= '0;
      shadow_q <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      fill_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      fill_q <= fill_d;

      if (accept) begin
        if (beat_q == LAST_BEAT) begin
          // Bits of the last beat above INST_LEN are dropped here.
          mem_q[wr_q] <= {s_data[LAST_W-1:0], shadow_q};
          wr_q        <= wr_q + DEPTH_LOG'(1);
          pushed_q    <= pushed_q + CNT_LEN'(1);
          beat_q      <= '0;
        end else begin
          for (int unsigned k = 0; k < BEATS - 1; k++)
            if (beat_q == BEAT_W'(k))
              shadow_q[k*BUS_W +: BUS_W] <= s_data;
          beat_q <= beat_q + BEAT_W'(1);
        end
      end

      if (pop) begin
        rd_q     <= rd_q + DEPTH_LOG'(1);
        popped_q <= popped_q + CNT_LEN'(1);
      end

      if (inst_req && (fill_q == '0))
        err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (prog_start) begin
            num_q    <= prog_inst_num;
            pushed_q <= '0;
            popped_q <= '0;
            err_q    <= 1'b0;
            if (prog_inst_num == '0)
              done_q <= 1'b1;
            else
              state_q <= RUN;
          end
        end
        RUN: begin
          if (pop && ((popped_q + CNT_LEN'(1)) == num_q)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instruct      = mem_q[rd_q];
  assign inst_empty    = (fill_q == '0);
  assign busy          = (state_q == RUN);
  assign done          = done_q;
  assign fill_level    = fill_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios with random beat data and
// random handshakes, compared each cycle against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int unsigned INST_LEN  = 220;
  localparam int unsigned BUS_W     = 64;
  localparam int unsigned BEATS     = 4;
  localparam int unsigned DEPTH_LOG = 4;
  localparam int unsigned CNT_LEN   = 16;
  localparam int unsigned DEPTH     = 1 << DEPTH_LOG;

  logic                clk = 1'b0;
  logic                rst;
  logic                prog_start;
  logic [CNT_LEN-1:0]  prog_inst_num;
  logic [BUS_W-1:0]    s_data;
  logic                s_valid;
  logic                s_ready;
  logic [INST_LEN-1:0] instruct;
  logic                inst_empty;
  logic                inst_req;
  logic                busy;
  logic                done;
  logic [DEPTH_LOG:0]  fill_level;
  logic                err_underflow;

  always #5 clk = ~clk;

  inst_fetch_queue #(
    .INST_LEN (INST_LEN),
    .BUS_W    (BUS_W),
    .BEATS    (BEATS),
    .DEPTH_LOG(DEPTH_LOG),
    .CNT_LEN  (CNT_LEN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .prog_start   (prog_start),
    .prog_inst_num(prog_inst_num),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .instruct     (instruct),
    .inst_empty   (inst_empty),
    .inst_req     (inst_req),
    .busy         (busy),
    .done         (done),
    .fill_level   (fill_level),
    .err_underflow(err_underflow)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: instruction queue, pending beats, program bookkeeping.
  logic [INST_LEN-1:0] mq[$];
  logic [BUS_W-1:0]    mb[$];
  bit                  m_run, m_err, m_done;
  int                  m_num, m_pushed, m_popped;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic bit exp_ready();
    return m_run && (m_pushed < m_num) && ((mb.size() != BEATS - 1) || (mq.size() < DEPTH));
  endfunction

  task automatic model_reset();
    mq.delete();
    mb.delete();
    m_run = 0; m_err = 0; m_done = 0;
    m_num = 0; m_pushed = 0; m_popped = 0;
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_s_ready"}, s_ready, 0);
    chk({pfx, "_inst_empty"}, inst_empty, 1);
    chk({pfx, "_instruct"}, instruct, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_fill"}, fill_level, 0);
    chk({pfx, "_err"}, err_underflow, 0);
  endtask

  task automatic drive(input bit ps, input int unsigned pn, input bit v,
                       input logic [BUS_W-1:0] d, input bit rq);
    prog_start    = ps;
    prog_inst_num = CNT_LEN'(pn);
    s_valid       = v;
    s_data        = d;
    inst_req      = rq;
  endtask

  // One clock: check s_ready, advance model on the edge, check registered outputs after it.
  task automatic tick();
    bit rdy, acc, pop, und, was_run;
    logic [BEATS*BUS_W-1:0] full;
    rdy = exp_ready();
    chk("s_ready", s_ready, rdy);
    acc = s_valid && rdy;
    pop = inst_req && (mq.size() > 0);
    und = inst_req && (mq.size() == 0);
    was_run = m_run;
    @(posedge clk);
    m_done = 0;
    if (pop) begin
      void'(mq.pop_front());
      m_popped++;
      if (m_run && m_popped == m_num) begin
        m_run = 0;
        m_done = 1;
      end
    end
    if (und) m_err = 1;
    if (acc) begin
      mb.push_back(s_data);
      if (mb.size() == BEATS) begin
        full = '0;
        for (int k = 0; k < BEATS; k++) full[k*BUS_W +: BUS_W] = mb[k];
        mq.push_back(full[INST_LEN-1:0]);
        mb.delete();
        m_pushed++;
      end
    end
    if (prog_start && !was_run) begin
      m_err = 0;
      if (prog_inst_num == 0) m_done = 1;
      else begin
        m_run = 1;
        m_num = int'(prog_inst_num);
        m_pushed = 0;
        m_popped = 0;
      end
    end
    #1;
    chk("inst_empty", inst_empty, mq.size() == 0);
    chk("fill_level", fill_level, mq.size());
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    chk("err_underflow", err_underflow, m_err);
    if (mq.size() > 0) chk("instruct", instruct, mq[0]);
  endtask

  task automatic start(input int unsigned n);
    drive(1, n, 0, '0, 0);
    tick();
    drive(0, 0, 0, '0, 0);
  endtask

  task automatic run_random(input int limit, input int vpct, input int rpct);
    int n = 0;
    while (m_run && n < limit) begin
      drive(0, 0, $urandom_range(99) < vpct, rnd64(), $urandom_range(99) < rpct);
      tick();
      n++;
    end
    drive(0, 0, 0, '0, 0);
    chk("program_finished", busy, 0);
  endtask

  initial begin
    logic [BUS_W-1:0] b3;
    int guard;
    rst = 1'b1;
    drive(0, 0, 0, '0, 0);
    model_reset();
    #12;
    chk_reset("por");
    rst = 1'b0;

    // Single instruction with fixed beats
    start(1);
    drive(0, 0, 1, 64'h1111111111111111, 0); tick();
    drive(0, 0, 1, 64'h2222222222222222, 0); tick();
    drive(0, 0, 1, 64'h3333333333333333, 0); tick();
    b3 = 64'h4444444444444444;
    drive(0, 0, 1, b3, 0); tick();
    chk("t1_empty", inst_empty, 0);
    chk("t1_lo", instruct[63:0], 64'h1111111111111111);
    chk("t1_hi", instruct[219:192], b3[27:0]);
    drive(0, 0, 0, '0, 1); tick();
    chk("t1_done", done, 1);
    drive(0, 0, 0, '0, 0); tick();

    // Zero-length program
    start(0);
    chk("num0_done", done, 1);
    chk("num0_busy", busy, 0);
    tick();
    tick();

    // Full FIFO and backpressure
    start(20);
    for (int i = 0; i < 80; i++) begin
      drive(0, 0, 1, rnd64(), 0);
      tick();
    end
    chk("full_fill", fill_level, 16);
    chk("full_ready", s_ready, 0);
    drive(0, 0, 1, rnd64(), 1); tick();
    chk("bp_ready_after_pop", s_ready, 1);
    drive(0, 0, 1, rnd64(), 0); tick();
    chk("bp_17th_landed", fill_level, 16);
    run_random(2000, 100, 50);

    // Simultaneous push and pop at fill level 5
    start(10);
    guard = 0;
    while (!(mq.size() == 5 && mb.size() == BEATS - 1) && guard < 200) begin
      drive(0, 0, 1, rnd64(), 0);
      tick();
      guard++;
    end
    chk("sim_reach_timeout", guard < 200, 1);
    drive(0, 0, 1, rnd64(), 1); tick();
    chk("sim_fill", fill_level, 5);
    run_random(2000, 80, 40);

    // Underflow, sticky until next program start
    start(2);
    drive(0, 0, 0, '0, 1); tick();
    chk("uf_err", err_underflow, 1);
    chk("uf_fill", fill_level, 0);
    run_random(2000, 80, 30);
    chk("uf_sticky", err_underflow, 1);
    start(1);
    chk("uf_clear", err_underflow, 0);
    run_random(2000, 80, 30);

    // prog_start during RUN is ignored
    start(3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, rnd64(), 0);
      tick();
    end
    drive(1, 7, 1, rnd64(), 0); tick();
    run_random(2000, 80, 40);

    // Random programs
    for (int p = 0; p < 4; p++) begin
      start($urandom_range(30, 1));
      run_random(3000, 70, 30);
    end

    // Reset mid-operation: after beat 2 of instruction 3
    start(5);
    guard = 0;
    while (!(m_pushed == 2 && mb.size() == 3) && guard < 100) begin
      drive(0, 0, 1, rnd64(), 0);
      tick();
      guard++;
    end
    chk("mid_reach_timeout", guard < 100, 1);
    drive(0, 0, 0, '0, 0);
    #3;
    rst = 1'b1;
    #1;
    chk_reset("mid");
    model_reset();
    #10;
    rst = 1'b0;
    start(1);
    for (int i = 0; i < BEATS; i++) begin
      drive(0, 0, 1, rnd64(), 0);
      tick();
    end
    chk("fresh_not_empty", inst_empty, 0);
    run_random(200, 0, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Upstream neighbour of topcontrol. Receives the instruction stream as BUS_W-bit beats from the host/DMA path.
- Assembles each INST_LEN-bit instruction from BEATS beats and buffers it in a DEPTH-entry FIFO.
- Presents the FIFO head first-word-fall-through on instruct/inst_empty; topcontrol pops it with its one-cycle inst_req pulse.
- A program-level counter bounds the fetch and reports completion.

Parameters:
- INST_LEN, 220, instruction width; must match topcontrol.
- BUS_W, 64, input beat width.
- BEATS, 4, beats per instruction, equal to ceil(INST_LEN/BUS_W).
- DEPTH_LOG, 4, log2 of FIFO depth; DEPTH = 16 entries.
- CNT_LEN, 16, width of the instruction counters.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous active-high reset.
- prog_start  in  1  pulse; latches prog_inst_num and begins a program.
- prog_inst_num  in  CNT_LEN  number of instructions in the program.
- s_data  in  BUS_W  instruction beat.
- s_valid  in  1  beat valid.
- s_ready  out  1  beat accepted when s_valid && s_ready.
- instruct  out  INST_LEN  FIFO head instruction.
- inst_empty  out  1  FIFO empty.
- inst_req  in  1  pop: each clk edge with inst_req=1 removes the head.
- busy  out  1  program in progress.
- done  out  1  one-cycle pulse when the last instruction is popped.
- fill_level  out  DEPTH_LOG+1  current FIFO occupancy.
- err_underflow  out  1  sticky; set by inst_req while inst_empty.

Behaviour:
- Reset: asynchronous, active-high, clears all state at any time, including mid-instruction and mid-program. After reset:
  - s_ready=0, inst_empty=1, instruct=0, busy=0, done=0, fill_level=0, err_underflow=0.
  - beat_cnt, pushed_cnt, popped_cnt and the pointers are 0.
  - A partially assembled instruction is discarded.
- States:
  - IDLE: s_ready=0. prog_start moves to RUN: latches num, zeroes pushed_cnt, popped_cnt and err_underflow.
  - IDLE, prog_inst_num=0: no RUN; done pulses on the next cycle.
  - RUN: busy=1.
  - RUN to IDLE: when popped_cnt reaches num, done pulses for exactly one cycle.
  - prog_start while busy is ignored.
- Assembly:
  - Beat k (0..BEATS-1) fills bits [k*BUS_W +: BUS_W] of a BEATS*BUS_W shadow register. Bits at and above INST_LEN are discarded.
  - beat_cnt wraps from BEATS-1 to 0.
  - Acceptance of the last beat pushes {shadow[INST_LEN-BUS_W*(BEATS-1)-1:0 of last beat], earlier beats} into FIFO[wr_ptr], and increments pushed_cnt.
- s_ready:
  - s_ready = RUN && pushed_cnt<num && (beat_cnt!=BEATS-1 || fill_level<DEPTH).
  - Beats beyond num instructions are never accepted.
  - No pop-to-push bypass: at full, a pop frees space from the next cycle.
- Output:
  - instruct = FIFO[rd_ptr]; inst_empty = (fill_level==0). Both come directly from registers with no combinational path from s_* or inst_req.
  - Latency from last-beat acceptance into an empty FIFO to inst_empty=0 is 1 cycle.
  - After a pop edge, the next entry (or empty) is visible in the following cycle.
  - instruct is held stable while inst_empty=0 and no pop occurs.
- Pop: inst_req && !inst_empty advances rd_ptr and increments popped_cnt.
  - inst_req while empty: no pointer or count change; sets err_underflow.
  - Each high cycle counts as one pop; topcontrol pulses inst_req for one cycle per consumed instruction.
- Simultaneous push and pop: fill_level unchanged, both pointers advance.
- Pointers are DEPTH_LOG bits and wrap modulo DEPTH. fill_level ranges 0..DEPTH.
- All counters compare in CNT_LEN bits with no overflow; num is at most 2^CNT_LEN-1.

Test Plan:
- Single instruction: reset, prog_start with num=1, 4 beats 0x11..,0x22..,0x33..,0x44.. back-to-back.
  - Expect inst_empty=0 one cycle after beat 3.
  - Expect instruct[63:0]=beat0 and instruct[219:192]=beat3[27:0].
  - One inst_req pulse: inst_empty=1 next cycle, done pulses, busy drops.
- Full and backpressure: num=20, no pops.
  - After 16 instructions, fill_level=16 and s_ready=0 while beat_cnt=3.
  - One pop gives s_ready=1 the following cycle; the 17th instruction lands.
  - All 20 instructions pop in order.
- Simultaneous push and pop at fill_level=5: last beat accepted on the same edge as inst_req=1.
  - Expect fill_level remains 5 and the head advances.
- Underflow: inst_req=1 with FIFO empty in RUN.
  - Expect err_underflow=1 and fill_level=0, unchanged.
  - The next prog_start clears err_underflow.
- Reset mid-operation: assert rst after beat 2 of instruction 3, then release and start num=1.
  - Expect all outputs at reset values immediately.
  - The first new instruction is assembled from fresh beats only.
- Edge programs:
  - num=0: done pulses once and busy stays 0.
  - prog_start during RUN: no effect on num or counters.
